// File: rtl/logic_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// logic_sweep_checker_if
// Signal bundle between the sweep checker and its surroundings.
//   start        : sweep request (driven by the controller side)
//   dut_out      : output of the 4-input block under test
//   stim_a..d    : vector applied to the block under test, {A,B,C,D} = idx
//   busy, done   : sweep status; done is a one-cycle pulse
//   truth_table  : captured outputs, bit i = dut_out for vector i
//   pass         : truth_table matched the golden table
//   state_dbg    : current FSM state, for checkers and waveform reading
// Optional (SWEEP_MISMATCH_LOG_EN): mismatch_cnt, first_bad_idx,
// first_bad_valid.
//
// Handshake: start is a level request. It is looked at only while the
// checker is idle (busy=0); a high start there is accepted on that edge and
// busy rises. Start while busy is ignored. The sweep ends with a single done
// pulse, after which busy falls and truth_table/pass hold until the next
// accepted start.
//
// Modports: master = controller/bench side, slave = checker side.
// ---------------------------------------------------------------------------
interface logic_sweep_checker_if;
  logic        start;
  logic        dut_out;
  logic        stim_a;
  logic        stim_b;
  logic        stim_c;
  logic        stim_d;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic        pass;
  logic [2:0]  state_dbg;
`ifdef SWEEP_MISMATCH_LOG_EN
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_bad_idx;
  logic        first_bad_valid;

  modport master (
    output start, dut_out,
    input  stim_a, stim_b, stim_c, stim_d, busy, done, truth_table, pass,
    input  state_dbg, mismatch_cnt, first_bad_idx, first_bad_valid
  );

  modport slave (
    input  start, dut_out,
    output stim_a, stim_b, stim_c, stim_d, busy, done, truth_table, pass,
    output state_dbg, mismatch_cnt, first_bad_idx, first_bad_valid
  );
`else
  modport master (
    output start, dut_out,
    input  stim_a, stim_b, stim_c, stim_d, busy, done, truth_table, pass,
    input  state_dbg
  );

  modport slave (
    input  start, dut_out,
    output stim_a, stim_b, stim_c, stim_d, busy, done, truth_table, pass,
    output state_dbg
  );
`endif
endinterface

// File: rtl/logic_sweep_checker.sv
// ---------------------------------------------------------------------------
// logic_sweep_checker
// Drives a 4-input combinational block through all 16 input combinations in
// ascending order, samples its output after a settle window and compares the
// assembled truth table against a golden constant.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : logic_sweep_checker_if.slave (start, dut_out, stim_*, busy,
//            done, truth_table, pass, state_dbg and optional mismatch log)
// Parameters:
//   SETTLE_CYCLES : cycles between applying a vector and sampling (0..15)
//   EXPECTED      : golden truth table, bit i = output for {A,B,C,D} = i
// Optional feature macro: SWEEP_MISMATCH_LOG_EN adds mismatch_cnt,
// first_bad_idx and first_bad_valid.
// ---------------------------------------------------------------------------
module logic_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hAAE0
) (
  input logic                   clk,
  input logic                   rst_n,
  logic_sweep_checker_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  stim_q, stim_d;
  logic        busy_q, busy_d;
  logic [15:0] table_q, table_d;
  logic        pass_q, pass_d;
`ifdef SWEEP_MISMATCH_LOG_EN
  logic [4:0]  mis_cnt_q, mis_cnt_d;
  logic [3:0]  first_idx_q, first_idx_d;
  logic        first_vld_q, first_vld_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      settle_q    <= 4'd0;
      stim_q      <= 4'd0;
      busy_q      <= 1'b0;
      table_q     <= 16'd0;
      pass_q      <= 1'b0;
`ifdef SWEEP_MISMATCH_LOG_EN
      mis_cnt_q   <= 5'd0;
      first_idx_q <= 4'd0;
      first_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      table_q     <= table_d;
      pass_q      <= pass_d;
`ifdef SWEEP_MISMATCH_LOG_EN
      mis_cnt_q   <= mis_cnt_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    table_d     = table_q;
    pass_d      = pass_q;
`ifdef SWEEP_MISMATCH_LOG_EN
    mis_cnt_d   = mis_cnt_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = APPLY;
          idx_d   = 4'd0;
          stim_d  = 4'd0;
          busy_d  = 1'b1;
          table_d = 16'd0;
          pass_d  = 1'b0;
`ifdef SWEEP_MISMATCH_LOG_EN
          mis_cnt_d   = 5'd0;
          first_idx_d = 4'd0;
          first_vld_d = 1'b0;
`endif
        end
      end
      APPLY: begin
        stim_d   = idx_q;
        settle_d = SETTLE_LOAD;
        // With no settle window the sample happens in the very next cycle.
        state_d  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        // Leaving at 1 makes the window exactly SETTLE_CYCLES cycles long.
        if (settle_q <= 4'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[idx_q] = bus.dut_out;
`ifdef SWEEP_MISMATCH_LOG_EN
        if (bus.dut_out != EXPECTED[idx_q]) begin
          mis_cnt_d = mis_cnt_q + 5'd1;
          if (!first_vld_q) begin
            first_idx_d = idx_q;
            first_vld_d = 1'b1;
          end
        end
`endif
        if (idx_q == 4'd15) begin
          // Verdict uses the table including the bit captured right now.
          pass_d  = (table_d == EXPECTED);
          stim_d  = 4'd0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = APPLY;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.stim_a      = stim_q[3];
  assign bus.stim_b      = stim_q[2];
  assign bus.stim_c      = stim_q[1];
  assign bus.stim_d      = stim_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = (state_q == DONE);
  assign bus.truth_table = table_q;
  assign bus.pass        = pass_q;
  assign bus.state_dbg   = state_q;
`ifdef SWEEP_MISMATCH_LOG_EN
  assign bus.mismatch_cnt    = mis_cnt_q;
  assign bus.first_bad_idx   = first_idx_q;
  assign bus.first_bad_valid = first_vld_q;
`endif

endmodule

// File: tb/tb_logic_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_logic_sweep_checker
// Directed bench for logic_sweep_checker. Two instances: dut2 with a settle
// window of 2 cycles, dut0 with no settle window. Each is wrapped around the
// reference function (A|B)&(~B|C|D)&(~A|D); dut2 can also be stuck at 0.
// ---------------------------------------------------------------------------
module tb_logic_sweep_checker;

  logic clk;
  logic rst_n;
  logic stuck;

  int tests;
  int fails;

  logic [3:0] stim_log [0:199];
  logic       busy_log [0:199];

  logic_sweep_checker_if bus2 ();
  logic_sweep_checker_if bus0 ();

  function automatic logic golden(input logic a, input logic b, input logic c, input logic d);
    return (a | b) & (~b | c | d) & (~a | d);
  endfunction

  assign bus2.dut_out = stuck ? 1'b0 : golden(bus2.stim_a, bus2.stim_b, bus2.stim_c, bus2.stim_d);
  assign bus0.dut_out = golden(bus0.stim_a, bus0.stim_b, bus0.stim_c, bus0.stim_d);

  logic_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED(16'hAAE0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  logic_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(16'hAAE0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] stim_of(input bit use0);
    if (use0) return {bus0.stim_a, bus0.stim_b, bus0.stim_c, bus0.stim_d};
    return {bus2.stim_a, bus2.stim_b, bus2.stim_c, bus2.stim_d};
  endfunction

  task automatic set_start(input bit use0, input logic v);
    if (use0) bus0.start = v;
    else      bus2.start = v;
  endtask

  // Pulses start, then watches max_cycles edges after the accepting edge.
  // Edge n is sampled 1 time unit after it. An extra one-cycle start pulse
  // is raised after edge pulse_at (if >= 0). done_at = -1 if no done seen.
  task automatic sweep(input bit use0, input int max_cycles, input int pulse_at,
                       output int done_at, output int done_cnt);
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk);
    set_start(use0, 1'b1);
    @(posedge clk);
    #1;
    set_start(use0, 1'b0);
    stim_log[0] = stim_of(use0);
    busy_log[0] = use0 ? bus0.busy : bus2.busy;
    for (int n = 1; n <= max_cycles && n < 200; n++) begin
      @(posedge clk);
      #1;
      set_start(use0, (n == pulse_at));
      stim_log[n] = stim_of(use0);
      busy_log[n] = use0 ? bus0.busy : bus2.busy;
      if (use0 ? bus0.done : bus2.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    stuck = 1'b0;
    bus2.start = 1'b0;
    bus0.start = 1'b0;
    #23;
    tests++;
    if ({stim_of(0), bus2.busy, bus2.done, bus2.truth_table, bus2.pass} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: got stim=%b busy=%b done=%b tt=%h pass=%b, want all 0",
               stim_of(0), bus2.busy, bus2.done, bus2.truth_table, bus2.pass);
    end
    tests++;
    if (bus2.state_dbg !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d want 0", bus2.state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden;
    int da, dc;
    sweep(0, 80, -1, da, dc);
    tests++;
    if (da !== 64) begin fails++; $display("FAIL golden_done_at: got %0d want 64", da); end
    tests++;
    if (dc !== 1) begin fails++; $display("FAIL golden_done_cnt: got %0d want 1", dc); end
    tests++;
    if (bus2.truth_table !== 16'hAAE0) begin
      fails++; $display("FAIL golden_table: got %h want aae0", bus2.truth_table);
    end
    tests++;
    if (bus2.pass !== 1'b1) begin fails++; $display("FAIL golden_pass: got %b want 1", bus2.pass); end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (stim_log[4*k+1] !== 4'(k)) begin
        fails++;
        $display("FAIL golden_stim[%0d]: got %b want %b", k, stim_log[4*k+1], 4'(k));
      end
    end
    tests++;
    if (stim_log[64] !== 4'd0) begin fails++; $display("FAIL golden_stim_end: got %b want 0000", stim_log[64]); end
    tests++;
    if ({busy_log[1], busy_log[64], busy_log[65]} !== 3'b110) begin
      fails++;
      $display("FAIL golden_busy: got %b%b%b want 110", busy_log[1], busy_log[64], busy_log[65]);
    end
`ifdef SWEEP_MISMATCH_LOG_EN
    tests++;
    if (bus2.mismatch_cnt !== 5'd0 || bus2.first_bad_valid !== 1'b0) begin
      fails++;
      $display("FAIL golden_mislog: got cnt=%0d valid=%b want 0/0", bus2.mismatch_cnt, bus2.first_bad_valid);
    end
`endif
  endtask

  task automatic test_hold_and_async_reset;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (bus2.truth_table !== 16'hAAE0 || bus2.pass !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: got tt=%h pass=%b want aae0/1", bus2.truth_table, bus2.pass);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus2.truth_table !== 16'd0 || bus2.pass !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_idle: got tt=%h pass=%b want 0000/0", bus2.truth_table, bus2.pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stuck;
    int da, dc;
    stuck = 1'b1;
    sweep(0, 70, -1, da, dc);
    stuck = 1'b0;
    tests++;
    if (da !== 64) begin fails++; $display("FAIL stuck_done_at: got %0d want 64", da); end
    tests++;
    if (bus2.truth_table !== 16'h0000) begin
      fails++; $display("FAIL stuck_table: got %h want 0000", bus2.truth_table);
    end
    tests++;
    if (bus2.pass !== 1'b0) begin fails++; $display("FAIL stuck_pass: got %b want 0", bus2.pass); end
`ifdef SWEEP_MISMATCH_LOG_EN
    tests++;
    if (bus2.mismatch_cnt !== 5'd7) begin fails++; $display("FAIL stuck_mis_cnt: got %0d want 7", bus2.mismatch_cnt); end
    tests++;
    if (bus2.first_bad_idx !== 4'd5 || bus2.first_bad_valid !== 1'b1) begin
      fails++;
      $display("FAIL stuck_first_bad: got idx=%0d valid=%b want 5/1", bus2.first_bad_idx, bus2.first_bad_valid);
    end
`endif
  endtask

  task automatic test_ignored_start;
    int da, dc;
    sweep(0, 80, 20, da, dc);
    tests++;
    if (da !== 64) begin fails++; $display("FAIL ignored_start_done_at: got %0d want 64", da); end
    tests++;
    if (dc !== 1) begin fails++; $display("FAIL ignored_start_done_cnt: got %0d want 1", dc); end
    tests++;
    if (bus2.pass !== 1'b1) begin fails++; $display("FAIL ignored_start_pass: got %b want 1", bus2.pass); end
  endtask

  task automatic test_reset_mid_sweep;
    int da, dc, dcnt, bcnt;
    sweep(0, 30, -1, da, dc);
    tests++;
    if (bus2.truth_table !== 16'h0060) begin
      fails++; $display("FAIL midsweep_partial_table: got %h want 0060", bus2.truth_table);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({stim_of(0), bus2.busy, bus2.done, bus2.truth_table} !== 22'd0) begin
      fails++;
      $display("FAIL midsweep_reset: got stim=%b busy=%b done=%b tt=%h want all 0",
               stim_of(0), bus2.busy, bus2.done, bus2.truth_table);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk);
      #1;
      if (bus2.done) dcnt++;
      if (bus2.busy) bcnt++;
    end
    tests++;
    if (dcnt !== 0 || bcnt !== 0) begin
      fails++; $display("FAIL midsweep_no_done: got done=%0d busy=%0d cycles want 0/0", dcnt, bcnt);
    end
    sweep(0, 70, -1, da, dc);
    tests++;
    if (da !== 64 || bus2.pass !== 1'b1) begin
      fails++; $display("FAIL midsweep_restart: got done_at=%0d pass=%b want 64/1", da, bus2.pass);
    end
  endtask

  task automatic test_start_held;
    int d1, d2;
    logic pass66;
    d1 = -1;
    d2 = -1;
    pass66 = 1'bx;
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      #1;
      if (n == 70) bus2.start = 1'b0;
      busy_log[n] = bus2.busy;
      if (n == 66) pass66 = bus2.pass;
      if (bus2.done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    tests++;
    if (d1 !== 64 || d2 !== 130) begin
      fails++; $display("FAIL held_done_at: got %0d,%0d want 64,130", d1, d2);
    end
    tests++;
    if ({busy_log[65], busy_log[66]} !== 2'b01) begin
      fails++; $display("FAIL held_restart_busy: got %b%b want 01", busy_log[65], busy_log[66]);
    end
    tests++;
    if (pass66 !== 1'b0) begin fails++; $display("FAIL held_pass_cleared: got %b want 0", pass66); end
    tests++;
    if (bus2.pass !== 1'b1) begin fails++; $display("FAIL held_pass_final: got %b want 1", bus2.pass); end
  endtask

  task automatic test_settle0;
    int da, dc;
    sweep(1, 50, -1, da, dc);
    tests++;
    if (da !== 32 || dc !== 1) begin
      fails++; $display("FAIL settle0_done: got at=%0d cnt=%0d want 32/1", da, dc);
    end
    tests++;
    if (bus0.truth_table !== 16'hAAE0 || bus0.pass !== 1'b1) begin
      fails++; $display("FAIL settle0_table: got tt=%h pass=%b want aae0/1", bus0.truth_table, bus0.pass);
    end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (stim_log[2*k+1] !== 4'(k)) begin
        fails++;
        $display("FAIL settle0_stim[%0d]: got %b want %b", k, stim_log[2*k+1], 4'(k));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_golden();
    test_hold_and_async_reset();
    test_stuck();
    test_ignored_start();
    test_reset_mid_sweep();
    test_start_held();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
